// File: rtl/shabal_host.sv
// Host-side sequencer for a 16-bit Shabal accelerator: splits 32-bit message
// words into half-word loads and reassembles fetched digest halves into words.
module shabal_host #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_data,
  input  logic        msg_last,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic        dig_last,
  output logic        busy,
  output logic        err,
  output logic        init,
  output logic        load,
  output logic        fetch,
  output logic [15:0] idata,
  input  logic        ack,
  input  logic [15:0] odata
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, INIT, GET, LD, LGAP, FT, FGAP, OUT, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic          last_q, last_d;
  logic          half_q, half_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          fhalf_q, fhalf_d;
  logic [2:0]    dcnt_q, dcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          init_q, init_d;
  logic          load_q, load_d;
  logic          fetch_q, fetch_d;
  logic [15:0]   idata_q, idata_d;
  logic          msg_ready_q, msg_ready_d;
  logic          dig_valid_q, dig_valid_d;
  logic [31:0]   dig_data_q, dig_data_d;
  logic          dig_last_q, dig_last_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    half_d     = half_q;
    wcnt_d     = wcnt_q;
    fhalf_d    = fhalf_q;
    dcnt_d     = dcnt_q;
    tmo_d      = tmo_q;
    dig_data_d = dig_data_q;
    err_d      = err_q;

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d = INIT;
          err_d   = 1'b0;
          wcnt_d  = '0;
          dcnt_d  = '0;
          fhalf_d = 1'b0;
        end
      end
      INIT: state_d = GET;
      GET: begin
        if (msg_valid && msg_ready_q) begin
          word_d  = msg_data;
          last_d  = msg_last;
          wcnt_d  = wcnt_q + 4'd1;
          half_d  = 1'b0;
          state_d = LD;
        end
      end
      LD, FT: begin
        if (ack) begin
          if (state_q == FT) begin
            if (!fhalf_q) dig_data_d[31:16] = odata;
            else          dig_data_d[15:0]  = odata;
          end
          state_d = (state_q == LD) ? LGAP : FGAP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      LGAP: begin
        // wcnt has already advanced past the current word, so 0 means index 15
        if (!half_q) begin
          half_d  = 1'b1;
          state_d = LD;
        end else if (wcnt_q == 4'd0 && last_q) begin
          fhalf_d = 1'b0;
          dcnt_d  = '0;
          state_d = FT;
        end else begin
          state_d = GET;
        end
      end
      FGAP: begin
        if (!fhalf_q) begin
          fhalf_d = 1'b1;
          state_d = FT;
        end else begin
          fhalf_d = 1'b0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (dig_ready && dig_valid_q) begin
          if (dcnt_q == 3'd7) begin
            state_d = IDLE;
          end else begin
            dcnt_d  = dcnt_q + 3'd1;
            state_d = FT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == LD || state_d == FT) && state_d != state_q) tmo_d = '0;
    if (state_d == ERR) err_d = 1'b1;

    init_d      = (state_d == INIT);
    load_d      = (state_d == LD);
    fetch_d     = (state_d == FT);
    msg_ready_d = (state_d == GET);
    dig_valid_d = (state_d == OUT);
    dig_last_d  = (state_d == OUT) && (dcnt_d == 3'd7);
    busy_d      = (state_d != IDLE) && (state_d != ERR);
    idata_d     = '0;
    if (state_d == LD) idata_d = half_d ? word_d[15:0] : word_d[31:16];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      last_q      <= 1'b0;
      half_q      <= 1'b0;
      wcnt_q      <= '0;
      fhalf_q     <= 1'b0;
      dcnt_q      <= '0;
      tmo_q       <= '0;
      init_q      <= 1'b0;
      load_q      <= 1'b0;
      fetch_q     <= 1'b0;
      idata_q     <= '0;
      msg_ready_q <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_data_q  <= '0;
      dig_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      last_q      <= last_d;
      half_q      <= half_d;
      wcnt_q      <= wcnt_d;
      fhalf_q     <= fhalf_d;
      dcnt_q      <= dcnt_d;
      tmo_q       <= tmo_d;
      init_q      <= init_d;
      load_q      <= load_d;
      fetch_q     <= fetch_d;
      idata_q     <= idata_d;
      msg_ready_q <= msg_ready_d;
      dig_valid_q <= dig_valid_d;
      dig_data_q  <= dig_data_d;
      dig_last_q  <= dig_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign init      = init_q;
  assign load      = load_q;
  assign fetch     = fetch_q;
  assign idata     = idata_q;
  assign msg_ready = msg_ready_q;
  assign dig_valid = dig_valid_q;
  assign dig_data  = dig_data_q;
  assign dig_last  = dig_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
